// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared GMII receive constants, state encoding and idle classification
// Purpose: byte codes seen on the GMII receive path, the frame length limit,
//          the delimiter state encoding and a helper that classifies idle
//          (rx_dv=0) symbols carrying rx_er.
// Ports:   none (package)
package rs_pkg;

  localparam logic [7:0] PREAMBLE        = 8'h55;
  localparam logic [7:0] SFD             = 8'hD5;
  localparam logic [7:0] FALSE_CARRIER   = 8'h0E;
  localparam logic [7:0] CARRIER_EXT     = 8'h0F;
  localparam logic [7:0] CARRIER_EXT_ERR = 8'h1F;

  localparam int COUNT_W   = 11;
  localparam int MAX_COUNT = 2047;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_PREAMBLE  = 2'd2,
    ST_DATA      = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    IND_NONE          = 2'd0,
    IND_FALSE_CARRIER = 2'd1,
    IND_CARRIER_EXT   = 2'd2
  } idle_ind_t;

  // Meaning of an rx_dv=0 sample. Carrier extension codes are recognised so
  // they are explicitly distinct from a false carrier and never reported.
  function automatic idle_ind_t classify_idle(input logic er, input logic [7:0] d);
    idle_ind_t ind;
    ind = IND_NONE;
    if (er) begin
      case (d)
        FALSE_CARRIER:                ind = IND_FALSE_CARRIER;
        CARRIER_EXT, CARRIER_EXT_ERR: ind = IND_CARRIER_EXT;
        default:                      ind = IND_NONE;
      endcase
    end
    return ind;
  endfunction

endpackage

// File: rtl/rx_len_counter.sv
// rtl/rx_len_counter.sv - saturating frame length counter
// Purpose: counts frame bytes; clear wins over increment; holds at MAX_COUNT.
// Ports:   rx_clk, reset_n (async active-low), clear, inc -> count[COUNT_W-1:0]
module rx_len_counter
  import rs_pkg::*;
(
  input  logic               rx_clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != COUNT_W'(MAX_COUNT))) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_frame_delimiter.sv
// rtl/rx_frame_delimiter.sv - GMII receive frame delimiter (preamble/SFD strip, framing)
// Purpose: strips preamble and SFD, emits frame bytes one cycle late with
//          sof/eof markers, error flag and length, and reports dropped
//          receptions and false carrier.
// Ports:   rx_clk, reset_n (async active-low), rxd[7:0], rx_dv, rx_er
//          -> data_out[7:0], data_out_valid, sof, eof, frame_error,
//             byte_count[10:0], frame_dropped, false_carrier
module rx_frame_delimiter
  import rs_pkg::*;
(
  input  logic               rx_clk,
  input  logic               reset_n,
  input  logic [7:0]         rxd,
  input  logic               rx_dv,
  input  logic               rx_er,
  output logic [7:0]         data_out,
  output logic               data_out_valid,
  output logic               sof,
  output logic               eof,
  output logic               frame_error,
  output logic [COUNT_W-1:0] byte_count,
  output logic               frame_dropped,
  output logic               false_carrier
);

  rx_state_t          state_q, state_d;
  logic [7:0]         held_q, held_d;
  logic               held_valid_q, held_valid_d;
  logic               held_first_q, held_first_d;
  logic               err_q, err_d;
  logic               fc_seen_q, fc_seen_d;
  logic               cnt_clear, cnt_inc;
  logic [COUNT_W-1:0] cnt;

  logic [7:0]         data_d;
  logic               valid_d, sof_d, eof_d, ferr_d, drop_d, fc_d;
  logic [COUNT_W-1:0] bc_d;

  rx_len_counter u_len_counter (
    .rx_clk  (rx_clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (cnt)
  );

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_WAIT_IDLE;
      held_q         <= '0;
      held_valid_q   <= 1'b0;
      held_first_q   <= 1'b0;
      err_q          <= 1'b0;
      fc_seen_q      <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      sof            <= 1'b0;
      eof            <= 1'b0;
      frame_error    <= 1'b0;
      byte_count     <= '0;
      frame_dropped  <= 1'b0;
      false_carrier  <= 1'b0;
    end else begin
      state_q        <= state_d;
      held_q         <= held_d;
      held_valid_q   <= held_valid_d;
      held_first_q   <= held_first_d;
      err_q          <= err_d;
      fc_seen_q      <= fc_seen_d;
      data_out       <= data_d;
      data_out_valid <= valid_d;
      sof            <= sof_d;
      eof            <= eof_d;
      frame_error    <= ferr_d;
      byte_count     <= bc_d;
      frame_dropped  <= drop_d;
      false_carrier  <= fc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    held_first_d = held_first_q;
    err_d        = err_q;
    fc_seen_d    = 1'b0;
    cnt_clear    = 1'b1;
    cnt_inc      = 1'b0;
    data_d       = '0;
    valid_d      = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    ferr_d       = 1'b0;
    bc_d         = '0;
    drop_d       = 1'b0;
    fc_d         = 1'b0;

    case (state_q)
      ST_WAIT_IDLE: begin
        if (!rx_dv) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (rx_dv) begin
          if (rxd == PREAMBLE) begin
            state_d = ST_PREAMBLE;
          end else begin
            drop_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else if (classify_idle(rx_er, rxd) == IND_FALSE_CARRIER) begin
          // Report once per indication even if it spans several samples.
          fc_seen_d = 1'b1;
          fc_d      = !fc_seen_q;
        end
      end

      ST_PREAMBLE: begin
        if (!rx_dv) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_er || ((rxd != PREAMBLE) && (rxd != SFD))) begin
          drop_d  = 1'b1;
          state_d = ST_WAIT_IDLE;
        end else if (rxd == SFD) begin
          state_d      = ST_DATA;
          held_valid_d = 1'b0;
          err_d        = 1'b0;
        end
      end

      ST_DATA: begin
        cnt_clear = 1'b0;
        if (rx_dv) begin
          // Release the previously held byte and hold the new one, so the
          // last byte is still available when rx_dv drops to tag it eof.
          cnt_inc      = 1'b1;
          valid_d      = held_valid_q;
          data_d       = held_valid_q ? held_q : 8'h00;
          sof_d        = held_valid_q && held_first_q;
          held_d       = rxd;
          held_valid_d = 1'b1;
          held_first_d = !held_valid_q;
          if (rx_er) err_d = 1'b1;
        end else begin
          state_d      = ST_IDLE;
          held_valid_d = 1'b0;
          err_d        = 1'b0;
          if (held_valid_q) begin
            valid_d = 1'b1;
            data_d  = held_q;
            sof_d   = held_first_q;
            eof_d   = 1'b1;
            ferr_d  = err_q;
            bc_d    = cnt;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      default: state_d = ST_WAIT_IDLE;
    endcase
  end

endmodule
